// File: rtl/fb_loader.sv
// fb_loader: assembles a framed byte stream into 48-bit pixel-pair words
// and writes them into the panel image RAM at {img, 1'b0, row, col}.
// Frame: sync byte, image index, then 1024 words of 6 bytes (MSB first).
// Each word holds the top-half pixel in the upper 24 bits and the
// bottom-half pixel in the lower 24 bits.

module fb_loader #(
    parameter int          pixel_depth    = 8,
    parameter int          data_width     = 6 * pixel_depth,
    parameter int          addr_width     = 15,
    parameter int          num_images     = 12,
    parameter logic [7:0]  sync_byte      = 8'hA5,
    parameter int          timeout_cycles = 1000000
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Idle counter only needs to reach timeout_cycles-1.
    localparam int             tw           = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [tw-1:0]  idle_limit   = tw'(timeout_cycles - 1);
    localparam logic [7:0]     num_images_b = 8'(num_images);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INDEX = 2'd1,
        ST_PIXEL = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [3:0]              img_r;
    logic [9:0]              word_idx_r;
    logic [2:0]              byte_cnt_r;
    logic [data_width-1:0]   asm_r;
    logic [tw-1:0]           idle_cnt_r;

    logic                    wr_en_r;
    logic [addr_width-1:0]   wr_addr_r;
    logic [data_width-1:0]   wr_data_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    logic                    sync_hit_s;
    logic                    idx_ok_s;
    logic                    idx_bad_s;
    logic                    pix_byte_s;
    logic                    word_done_s;
    logic                    last_word_s;
    logic                    timeout_s;

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a received byte always takes priority over timeout.
    always_comb begin
        state_nxt_s = state_r;
        sync_hit_s  = 1'b0;
        idx_ok_s    = 1'b0;
        idx_bad_s   = 1'b0;
        pix_byte_s  = 1'b0;
        word_done_s = 1'b0;
        last_word_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (rx_data == sync_byte)) begin
                    sync_hit_s  = 1'b1;
                    state_nxt_s = ST_INDEX;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INDEX: begin
                if (rx_valid) begin
                    if (rx_data < num_images_b) begin
                        idx_ok_s    = 1'b1;
                        state_nxt_s = ST_PIXEL;
                    end else begin
                        idx_bad_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (idle_cnt_r == idle_limit) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INDEX;
                end
            end
            ST_PIXEL: begin
                if (rx_valid) begin
                    pix_byte_s = 1'b1;
                    if (byte_cnt_r == 3'd5) begin
                        word_done_s = 1'b1;
                        if (word_idx_r == 10'd1023) begin
                            last_word_s = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_PIXEL;
                        end
                    end else begin
                        state_nxt_s = ST_PIXEL;
                    end
                end else if (idle_cnt_r == idle_limit) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PIXEL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame counters and word assembly; a partial word is simply abandoned.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            img_r      <= 4'd0;
            word_idx_r <= 10'd0;
            byte_cnt_r <= 3'd0;
            asm_r      <= '0;
        end else if (idx_ok_s) begin
            img_r      <= rx_data[3:0];
            word_idx_r <= 10'd0;
            byte_cnt_r <= 3'd0;
            asm_r      <= asm_r;
        end else if (pix_byte_s) begin
            img_r      <= img_r;
            word_idx_r <= word_done_s ? (word_idx_r + 10'd1) : word_idx_r;
            byte_cnt_r <= (byte_cnt_r == 3'd5) ? 3'd0 : (byte_cnt_r + 3'd1);
            asm_r      <= {asm_r[data_width-9:0], rx_data};
        end else begin
            img_r      <= img_r;
            word_idx_r <= word_idx_r;
            byte_cnt_r <= byte_cnt_r;
            asm_r      <= asm_r;
        end
    end

    // Inter-byte idle counter: cleared by any byte, any state change, and in IDLE.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            idle_cnt_r <= '0;
        end else if (rx_valid || (state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + tw'(1);
        end
    end

    // Registered RAM write port and status outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            wr_en_r <= word_done_s;
            done_r  <= last_word_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (word_done_s) begin
                wr_addr_r <= addr_width'({img_r, 1'b0, word_idx_r});
                wr_data_r <= {asm_r[data_width-9:0], rx_data};
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
            if (sync_hit_s) begin
                err_r <= 1'b0;
            end else if (idx_bad_s || timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule
